// File: rtl/fetch_decode_buffer_pkg.sv
// Shared definitions for the fetch/decode pipeline boundary: the machine word
// width, the canonical NOP encoding, and the entry type carried between stages.
package pipelinePkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- what decode sees whenever no real entry is presented
  localparam logic [XLEN-1:0] NOP_INSTRUCTION = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus;
    logic [XLEN-1:0] instruction;
  } fetchDecodeEntry;

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Handshake bundle between fetch, the fetch/decode buffer and decode.
// The slave modport is the buffer's view; master is the surrounding pipeline.
interface fetch_decode_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             fetchValid;
  logic [XLEN-1:0]  fetchPc;
  logic [XLEN-1:0]  fetchPcPlus;
  logic [XLEN-1:0]  fetchInstruction;
  logic             fetchReady;

  logic             decodeValid;
  logic [XLEN-1:0]  decodePc;
  logic [XLEN-1:0]  decodePcPlus;
  logic [XLEN-1:0]  decodeInstruction;
  logic             decodeReady;

  logic             flush;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output fetchValid, fetchPc, fetchPcPlus, fetchInstruction,
    output decodeReady, flush,
    input  fetchReady, decodeValid, decodePc, decodePcPlus, decodeInstruction,
    input  occupancy
  );

  modport slave (
    input  fetchValid, fetchPc, fetchPcPlus, fetchInstruction,
    input  decodeReady, flush,
    output fetchReady, decodeValid, decodePc, decodePcPlus, decodeInstruction,
    output occupancy
  );

endinterface

// File: rtl/fetch_decode_buffer_storage.sv
// Entry array for the fetch/decode buffer: one synchronous write port and an
// asynchronous read port. Contents are deliberately not reset; validity is
// tracked by the pointer/occupancy logic in the parent.
module fetch_decode_storage
  import pipelinePkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            writeEnable,
  input  logic [PTR_W-1:0] writeAddress,
  input  fetchDecodeEntry writeData,
  input  logic [PTR_W-1:0] readAddress,
  output fetchDecodeEntry readData
);

  fetchDecodeEntry entries [DEPTH];

  // Capture the incoming entry at the write slot
  always_ff @(posedge clock) begin
    if (writeEnable) begin
      entries[writeAddress] <= writeData;
    end
  end

  assign readData = entries[readAddress];

endmodule

// File: rtl/fetch_decode_buffer.sv
// First-word-fall-through buffer between fetch and decode. Holds up to DEPTH
// {pc, pc+4, instruction} entries, back-pressures the PC when full and drops
// everything on a control-flow flush. fetchReady comes from registered state
// only, so a pop while full frees the slot for the following cycle.
module fetch_decode_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  fetch_decode_buffer_if.slave  bus
);

  import pipelinePkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [OCC_W-1:0] occupancy;

  logic            push;
  logic            pop;
  logic            headValid;
  fetchDecodeEntry writeEntry;
  fetchDecodeEntry headEntry;

  assign bus.fetchReady = (occupancy < FULL_COUNT);
  assign headValid      = (occupancy != '0) & ~bus.flush;
  assign push           = bus.fetchValid & bus.fetchReady & ~bus.flush;
  assign pop            = headValid & bus.decodeReady;

  assign writeEntry.pc          = bus.fetchPc;
  assign writeEntry.pcPlus      = bus.fetchPcPlus;
  assign writeEntry.instruction = bus.fetchInstruction;

  fetch_decode_storage #(
    .DEPTH (DEPTH)
  ) storage (
    .clock        (clock),
    .writeEnable  (push),
    .writeAddress (wrPtr),
    .writeData    (writeEntry),
    .readAddress  (rdPtr),
    .readData     (headEntry)
  );

  // Pointer and occupancy tracking; flush clears tracking ahead of any push/pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else if (bus.flush) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Present the head entry, or a zeroed NOP bubble when nothing is valid
  always_comb begin
    bus.decodeValid       = headValid;
    bus.decodePc          = '0;
    bus.decodePcPlus      = '0;
    bus.decodeInstruction = NOP_INSTRUCTION;
    if (headValid) begin
      bus.decodePc          = headEntry.pc;
      bus.decodePcPlus      = headEntry.pcPlus;
      bus.decodeInstruction = headEntry.instruction;
    end
  end

  assign bus.occupancy = occupancy;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer: every accepted fetch word is pushed
// to an expected queue, and the head of that queue is compared against the
// decode outputs each cycle.
module tb_fetch_decode_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [95:0] model [$];

  fetch_decode_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_decode_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic driveIdle();
    bus.fetchValid       = 1'b0;
    bus.fetchPc          = '0;
    bus.fetchPcPlus      = '0;
    bus.fetchInstruction = '0;
    bus.decodeReady      = 1'b0;
    bus.flush            = 1'b0;
  endtask

  task automatic checkCleared(input string tag);
    chk({tag, "_decodeValid"}, bus.decodeValid, 1'b0);
    chk({tag, "_occupancy"}, bus.occupancy, 0);
    chk({tag, "_decodePc"}, bus.decodePc, 0);
    chk({tag, "_decodePcPlus"}, bus.decodePcPlus, 0);
    chk({tag, "_decodeInstruction"}, bus.decodeInstruction, NOP);
  endtask

  task automatic checkOutputs(input logic fl);
    logic        expValid;
    logic [95:0] head;
    chk("fetchReady", bus.fetchReady, model.size() < DEPTH);
    chk("occupancy", bus.occupancy, model.size());
    chk("occBound", bus.occupancy <= DEPTH, 1'b1);
    expValid = (model.size() != 0) && !fl;
    chk("decodeValid", bus.decodeValid, expValid);
    if (expValid) begin
      head = model[0];
      chk("decodePc", bus.decodePc, head[95:64]);
      chk("decodePcPlus", bus.decodePcPlus, head[63:32]);
      chk("decodeInstruction", bus.decodeInstruction, head[31:0]);
    end else begin
      chk("bubblePc", bus.decodePc, 0);
      chk("bubblePcPlus", bus.decodePcPlus, 0);
      chk("bubbleInstruction", bus.decodeInstruction, NOP);
    end
  endtask

  // One clock: drive on the falling edge, check, then update the model at the rising edge
  task automatic runCycle(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                          input logic dr, input logic fl);
    logic doPush;
    logic doPop;
    @(negedge clk);
    bus.fetchValid       = fv;
    bus.fetchPc          = pc;
    bus.fetchPcPlus      = pc + 32'd4;
    bus.fetchInstruction = ins;
    bus.decodeReady      = dr;
    bus.flush            = fl;
    #1;
    checkOutputs(fl);
    doPush = fv && (model.size() < DEPTH) && !fl;
    doPop  = (model.size() != 0) && dr && !fl;
    @(posedge clk);
    if (fl) begin
      model.delete();
    end else begin
      if (doPop) void'(model.pop_front());
      if (doPush) model.push_back({pc, pc + 32'd4, ins});
    end
  endtask

  initial begin
    rst = 1'b0;
    driveIdle();

    // Reset held low: outputs clear without needing a release
    #12;
    checkCleared("reset");
    @(negedge clk);
    rst = 1'b1;
    runCycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming with decode always ready
    runCycle(1'b1, 32'h0, 32'h00500093, 1'b1, 1'b0);
    runCycle(1'b1, 32'h4, 32'h00A00113, 1'b1, 1'b0);
    runCycle(1'b1, 32'h8, 32'h002081B3, 1'b1, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill, back-pressure, then a single pop frees a slot one cycle later
    runCycle(1'b1, 32'h10, 32'h11111111, 1'b0, 1'b0);
    runCycle(1'b1, 32'h14, 32'h22222222, 1'b0, 1'b0);
    runCycle(1'b1, 32'h18, 32'h33333333, 1'b0, 1'b0);
    runCycle(1'b1, 32'h18, 32'h33333333, 1'b1, 1'b0);
    runCycle(1'b1, 32'h18, 32'h33333333, 1'b0, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Wrap-around: steady push+pop across several pointer wraps
    runCycle(1'b1, 32'h100, 32'hA0000000, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      runCycle(1'b1, 32'h100 + 32'(i * 4), 32'hA0000000 + 32'(i), 1'b1, 1'b0);
    end
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while full with a simultaneous push of PC 0x20
    runCycle(1'b1, 32'h30, 32'h44444444, 1'b0, 1'b0);
    runCycle(1'b1, 32'h34, 32'h55555555, 1'b0, 1'b0);
    runCycle(1'b1, 32'h20, 32'h66666666, 1'b1, 1'b1);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    runCycle(1'b1, 32'h24, 32'h77777777, 1'b1, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a full buffer
    runCycle(1'b1, 32'h50, 32'h88888888, 1'b0, 1'b0);
    runCycle(1'b1, 32'h54, 32'h99999999, 1'b0, 1'b0);
    @(negedge clk);
    driveIdle();
    #1;
    chk("preReset_occupancy", bus.occupancy, 2);
    #2;
    rst = 1'b0;
    #1;
    checkCleared("asyncReset");
    model.delete();
    @(negedge clk);
    rst = 1'b1;
    runCycle(1'b1, 32'h40, 32'h00100093, 1'b0, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    runCycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
